// File: rtl/status_flags_if.sv
// Handshake bundle between the ALU/branch unit and the status_flags stage.
// Master drives ALU status and branch requests; slave returns flags and decision.
interface status_flags_if;
    logic [3:0] status_in;
    logic       set_flags;
    logic       stall;
    logic       eval;
    logic [1:0] br_mode;
    logic [3:0] cond;
    logic [3:0] flags;
    logic       taken;
    logic       taken_valid;

    modport master (
        output status_in,
        output set_flags,
        output stall,
        output eval,
        output br_mode,
        output cond,
        input  flags,
        input  taken,
        input  taken_valid
    );

    modport slave (
        input  status_in,
        input  set_flags,
        input  stall,
        input  eval,
        input  br_mode,
        input  cond,
        output flags,
        output taken,
        output taken_valid
    );
endinterface

// File: rtl/status_flags.sv
// NZCV flag register and LEGv8 branch-condition evaluator.
// Decisions are registered; same-cycle set_flags is forwarded into B.cond.
module status_flags (
    input logic          clock,
    input logic          reset,
    status_flags_if.slave bus
);

    logic [3:0] flags_q;
    logic       taken_q;
    logic       valid_q;
    logic [3:0] eff;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       cond_hit;
    logic       decision;

    // Forward live status so a flag-setting op can branch on its own result
    assign eff = bus.set_flags ? bus.status_in : flags_q;
    assign z   = eff[3];
    assign n   = eff[2];
    assign c   = eff[1];
    assign v   = eff[0];

    always_comb begin
        cond_hit = 1'b1;
        case (bus.cond)
            4'd0:    cond_hit = z;
            4'd1:    cond_hit = !z;
            4'd2:    cond_hit = c;
            4'd3:    cond_hit = !c;
            4'd4:    cond_hit = n;
            4'd5:    cond_hit = !n;
            4'd6:    cond_hit = v;
            4'd7:    cond_hit = !v;
            4'd8:    cond_hit = c & !z;
            4'd9:    cond_hit = !(c & !z);
            4'd10:   cond_hit = (n == v);
            4'd11:   cond_hit = (n != v);
            4'd12:   cond_hit = !z & (n == v);
            4'd13:   cond_hit = !(!z & (n == v));
            default: cond_hit = 1'b1;
        endcase
    end

    always_comb begin
        decision = 1'b0;
        unique case (bus.br_mode)
            2'b00: decision = cond_hit;
            2'b01: decision = bus.status_in[3];
            2'b10: decision = !bus.status_in[3];
            2'b11: decision = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= 4'b0000;
            taken_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.stall) begin
            valid_q <= 1'b0;
        end else begin
            if (bus.set_flags)
                flags_q <= bus.status_in;
            if (bus.eval)
                taken_q <= decision;
            valid_q <= bus.eval;
        end
    end

    assign bus.flags       = flags_q;
    assign bus.taken       = taken_q;
    assign bus.taken_valid = valid_q;

endmodule

// File: tb/tb_status_flags.sv
// Bench for status_flags: directed vector table, then a random stream
// checked against an independent NZCV/branch model via a result queue.
module tb_status_flags;

    logic clock;
    logic reset;
    status_flags_if bus ();

    status_flags dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       rst;
        logic       sf;
        logic       st;
        logic       ev;
        logic [1:0] mode;
        logic [3:0] cnd;
        logic [3:0] sin;
        logic [3:0] e_flags;
        logic       e_taken;
        logic       e_valid;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] flags;
        logic       taken;
        logic       valid;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks;
    int   errors;

    logic [3:0] m_flags;
    logic       m_taken;
    logic       m_valid;

    function automatic vec_t mk(string nm, logic r, logic sf, logic st,
                                logic ev, logic [1:0] md, logic [3:0] cd,
                                logic [3:0] si, logic [3:0] ef,
                                logic et, logic evd);
        vec_t x;
        x.name = nm; x.rst = r; x.sf = sf; x.st = st; x.ev = ev;
        x.mode = md; x.cnd = cd; x.sin = si;
        x.e_flags = ef; x.e_taken = et; x.e_valid = evd;
        return x;
    endfunction

    // Condition grouped as base test plus inversion by the low bit
    function automatic logic model_dec(logic [3:0] f, logic [1:0] md,
                                       logic [3:0] cd, logic [3:0] si);
        logic zz, nn, cc, vv, base;
        logic [2:0] grp;
        zz = f[3]; nn = f[2]; cc = f[1]; vv = f[0];
        grp = cd[3:1];
        case (grp)
            3'd0: base = zz;
            3'd1: base = cc;
            3'd2: base = nn;
            3'd3: base = vv;
            3'd4: base = cc && !zz;
            3'd5: base = (nn == vv);
            3'd6: base = !zz && (nn == vv);
            default: base = 1'b1;
        endcase
        if (cd[0] && grp != 3'd7)
            base = !base;
        case (md)
            2'd0: return base;
            2'd1: return si[3];
            2'd2: return !si[3];
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step(logic r, logic sf, logic st, logic ev,
                              logic [1:0] md, logic [3:0] cd,
                              logic [3:0] si);
        logic [3:0] ef;
        if (r) begin
            m_flags = 4'b0; m_taken = 1'b0; m_valid = 1'b0;
        end else if (st) begin
            m_valid = 1'b0;
        end else begin
            ef = sf ? si : m_flags;
            if (ev)
                m_taken = model_dec(ef, md, cd, si);
            m_valid = ev;
            if (sf)
                m_flags = si;
        end
    endtask

    task automatic compare(exp_t e);
        checks++;
        if (bus.flags !== e.flags) begin
            errors++;
            $display("FAIL %s flags: got %b want %b", e.name, bus.flags, e.flags);
        end
        checks++;
        if (bus.taken !== e.taken) begin
            errors++;
            $display("FAIL %s taken: got %b want %b", e.name, bus.taken, e.taken);
        end
        checks++;
        if (bus.taken_valid !== e.valid) begin
            errors++;
            $display("FAIL %s taken_valid: got %b want %b",
                     e.name, bus.taken_valid, e.valid);
        end
    endtask

    task automatic cycle(string nm, logic r, logic sf, logic st, logic ev,
                         logic [1:0] md, logic [3:0] cd, logic [3:0] si,
                         exp_t e);
        exp_t got;
        reset         = r;
        bus.set_flags = sf;
        bus.stall     = st;
        bus.eval      = ev;
        bus.br_mode   = md;
        bus.cond      = cd;
        bus.status_in = si;
        e.name = nm;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty want 1 entry", nm);
        end else begin
            got = sb.pop_front();
            compare(got);
        end
    endtask

    initial begin
        logic [15:0] sweep;
        exp_t e;
        checks = 0;
        errors = 0;
        m_flags = 4'b0; m_taken = 1'b0; m_valid = 1'b0;

        tbl.push_back(mk("reset",    1,0,0,0,2'd0,4'd0, 4'b0000, 4'b0000,0,0));
        tbl.push_back(mk("set_z",    0,1,0,0,2'd0,4'd0, 4'b1000, 4'b1000,0,0));
        tbl.push_back(mk("eq_taken", 0,0,0,1,2'd0,4'd0, 4'b0000, 4'b1000,1,1));
        tbl.push_back(mk("idle_hold",0,0,0,0,2'd0,4'd0, 4'b0000, 4'b1000,1,0));
        tbl.push_back(mk("fwd_eq",   0,1,0,1,2'd0,4'd0, 4'b0000, 4'b0000,0,1));
        tbl.push_back(mk("fwd_lt",   0,1,0,1,2'd0,4'd11,4'b0100, 4'b0100,1,1));
        tbl.push_back(mk("cbz",      0,0,0,1,2'd1,4'd0, 4'b1000, 4'b0100,1,1));
        tbl.push_back(mk("cbnz",     0,0,0,1,2'd2,4'd0, 4'b1000, 4'b0100,0,1));
        tbl.push_back(mk("set_vc",   0,1,0,0,2'd0,4'd0, 4'b0011, 4'b0011,0,0));
        sweep = 16'b1110_1001_0110_0110;
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk($sformatf("sweep_c%0d", i), 0,0,0,1,2'd0,
                             4'(i), 4'b0000, 4'b0011, sweep[i], 1));
        tbl.push_back(mk("uncond",   0,0,0,1,2'd3,4'd0, 4'b0000, 4'b0011,1,1));
        tbl.push_back(mk("pre_stall",0,0,0,1,2'd0,4'd0, 4'b0000, 4'b0011,0,1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk($sformatf("stall%0d", i), 0,1,1,1,2'd3,4'd0,
                             4'b1111, 4'b0011,0,0));
        tbl.push_back(mk("unstall",  0,1,0,1,2'd3,4'd0, 4'b1111, 4'b1111,1,1));
        tbl.push_back(mk("b2b_lo",   0,0,0,1,2'd0,4'd3, 4'b0000, 4'b1111,0,1));
        tbl.push_back(mk("pre_rst",  0,1,0,1,2'd3,4'd0, 4'b0110, 4'b0110,1,1));
        tbl.push_back(mk("rst_prio", 1,1,0,1,2'd3,4'd0, 4'b1001, 4'b0000,0,0));
        tbl.push_back(mk("post_rst", 0,0,0,0,2'd0,4'd0, 4'b0000, 4'b0000,0,0));

        foreach (tbl[i]) begin
            e.flags = tbl[i].e_flags;
            e.taken = tbl[i].e_taken;
            e.valid = tbl[i].e_valid;
            model_step(tbl[i].rst, tbl[i].sf, tbl[i].st, tbl[i].ev,
                       tbl[i].mode, tbl[i].cnd, tbl[i].sin);
            cycle(tbl[i].name, tbl[i].rst, tbl[i].sf, tbl[i].st, tbl[i].ev,
                  tbl[i].mode, tbl[i].cnd, tbl[i].sin, e);
        end

        for (int i = 0; i < 400; i++) begin
            logic       r, sf, st, ev;
            logic [1:0] md;
            logic [3:0] cd, si;
            r  = ($urandom_range(0, 49) == 0);
            sf = $urandom_range(0, 2) == 0;
            st = $urandom_range(0, 4) == 0;
            ev = $urandom_range(0, 3) != 0;
            md = 2'($urandom_range(0, 3));
            cd = 4'($urandom_range(0, 15));
            si = 4'($urandom_range(0, 15));
            model_step(r, sf, st, ev, md, cd, si);
            e.flags = m_flags;
            e.taken = m_taken;
            e.valid = m_valid;
            cycle($sformatf("rand%0d", i), r, sf, st, ev, md, cd, si, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_flags.md
# status_flags

Flag-holding and branch-decision stage directly downstream of the 64-bit ALU. Captures the ALU's 4-bit status vector into an architectural NZCV register on flag-setting operations. Evaluates LEGv8 branch conditions (B.cond, CBZ, CBNZ, B) against either the held flags or the live ALU status. Delivers a registered taken/not-taken decision to the PC-select logic.

## Interface

Parameters:
- none; widths are fixed to the ALU status format.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- status_in  in  4  live ALU status: [0]=V overflow, [1]=C carry, [2]=N negative, [3]=Z zero.
- set_flags  in  1  latch status_in into the flag register this edge (ADDS/SUBS/ANDS class).
- stall  in  1  hold all state; suppresses set_flags and eval.
- eval  in  1  request a branch decision this cycle.
- br_mode  in  2  00=B.cond, 01=CBZ, 10=CBNZ, 11=unconditional B.
- cond  in  4  LEGv8 condition code; used only when br_mode=00.
- flags  out  4  held flag register, same bit order as status_in.
- taken  out  1  registered branch decision.
- taken_valid  out  1  one-cycle pulse; taken is meaningful only while high.

## Operation

- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- Flag register: on an edge with set_flags=1, stall=0, reset=0, flags <= status_in. Otherwise flags holds its value.
- Effective flags for a B.cond evaluation:
  - status_in when set_flags=1 in the same cycle (forwarding; never the stale value).
  - flags otherwise.
- Condition table (Z,N,C,V = effective flags):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 HS: C
  - 3 LO: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !(C&!Z)
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: !(!Z&(N==V))
  - 14, 15 AL: 1
- CBZ/CBNZ: decision is status_in[3] (CBZ) or !status_in[3] (CBNZ), using the live ALU zero of the register under test. They never read or modify flags unless set_flags is also asserted.
- br_mode=11: taken=1.
- Decision path: eval=1 and stall=0 at an edge gives taken <= decision and taken_valid <= 1 on that edge. If eval=0 or stall=1, taken_valid <= 0 and taken holds its value.
- Priority per edge: reset > stall > set_flags/eval. set_flags and eval are independent and may coincide.

## Timing

- Reset values: flags=4'b0000, taken=0, taken_valid=0, present after the first edge with reset=1.
- Reset asserted mid-operation overrides a coincident set_flags or eval; no decision pulse is produced for that cycle.
- Flag latency: status_in visible on flags one edge after set_flags.
- Decision latency: one cycle from eval to taken/taken_valid.
- Back-to-back eval on consecutive cycles produces consecutive taken_valid pulses, each reflecting its own cycle's inputs.
- stall=1 for N cycles freezes flags and taken, and holds taken_valid low for N cycles. A request presented during stall is dropped; the upstream stage re-presents it.
- No combinational path from any input to any output.

## Test plan

- Reset, then set_flags=1 with status_in=4'b1000 (Z), then eval, br_mode=00, cond=0 (EQ) -> flags=4'b1000; taken=1, taken_valid=1 one cycle after eval.
- Forwarding case:
  - Held flags=4'b0000.
  - Same cycle: set_flags=1, status_in=4'b0100 (N only), eval with cond=11 (LT).
  - Required: taken=1 (forwarded N!=V). A stale-flag evaluation would give 0 and is a failure.
  - Next cycle flags=4'b0100.
- CBZ/CBNZ:
  - status_in=4'b1000, set_flags=0, eval, br_mode=01 -> taken=1, flags unchanged.
  - Same inputs with br_mode=10 -> taken=0.
- Condition sweep with flags=4'b0011 (V=1, C=1, N=0, Z=0), cond 0..15 -> taken pattern in cond order 0,1,1,0,0,1,1,0,1,0,0,1,0,1,1,1.
- Stall:
  - stall=1 with set_flags=1, status_in=4'b1111, eval=1 for 3 cycles -> flags unchanged, taken_valid=0 throughout.
  - Release stall -> normal behaviour resumes.
- Reset priority:
  - flags=4'b0110, taken=1.
  - Assert reset together with set_flags=1, status_in=4'b1001, eval=1.
  - Required next cycle: flags=4'b0000, taken=0, taken_valid=0.
